gol_grid_reader: RTL and testbench
==================================

# gol_grid_reader

Streams one Game of Life generation out of the row-addressed grid memory as a raster-ordered pixel stream, one cell per beat, for the display path. It sits on the consumer side of the grid store that the next-state logic writes: on `start` it fetches rows 0..HEIGHT-1 over a one-cycle-latency read port, maps each cell to a 12-bit colour, and drives a valid/ready pixel interface with start-of-frame and end-of-line markers. A two-row prefetch buffer keeps the stream bubble-free while the sink holds `pix_ready` high.

## Interface
- `WIDTH`, 640, cells per row; must be ≥ 4
- `HEIGHT`, 480, rows per frame; must be ≥ 1
- `ALIVE_COLOR`, 12'hFFF, pixel value for a live cell
- `DEAD_COLOR`, 12'h000, pixel value for a dead cell
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle request to stream one frame; ignored while `busy`
- `busy`  out  1  high from the cycle after an accepted `start` through the last accepted beat
- `row_rd_en`  out  1  row read strobe
- `row_addr`  out  $clog2(HEIGHT)  row index being read
- `row_data`  in  WIDTH  row contents, valid exactly one cycle after `row_rd_en`; bit x = column x
- `pix_valid`  out  1  beat available
- `pix_ready`  in  1  sink accepts beat
- `pix_data`  out  12  colour of current cell
- `pix_sof`  out  1  current beat is cell (0,0)
- `pix_eol`  out  1  current beat is column WIDTH-1
- `frame_done`  out  1  single-cycle pulse after final beat accepted

## Operation
- States: IDLE, FETCH, STREAM.
- IDLE: `start`=1 → issue read of row 0 next cycle, go FETCH, `busy`=1.
- FETCH: wait for row 0 capture into front buffer; then STREAM with x=0, y=0.
- STREAM: `pix_data` = front[x] ? ALIVE_COLOR : DEAD_COLOR. Beat accepted when `pix_valid && pix_ready`; x increments; at x=WIDTH-1 accepted, x wraps to 0, y increments, back buffer swaps to front.
- Prefetch: whenever back buffer is empty and a next row (y+1 < HEIGHT) exists and no read is outstanding, assert `row_rd_en` with `row_addr`=y+1; capture `row_data` into back buffer the following cycle and mark it full.
- Row swap with back buffer not yet full: `pix_valid`=0 until capture (cannot occur with WIDTH ≥ 4 and the prefetch rule; bench checks it never happens).
- Last beat (x=WIDTH-1, y=HEIGHT-1) accepted → `frame_done`=1 next cycle, `busy`=0 same cycle as `frame_done`, return to IDLE.
- `start` coincident with `frame_done` cycle is accepted (IDLE by then).
- Counters: x width $clog2(WIDTH), y width $clog2(HEIGHT); no arithmetic beyond increment/compare.

## Timing
- Reset: all outputs 0, state IDLE, both buffers empty, counters 0; reset mid-frame abandons the frame, no `frame_done`.
- `start` sampled cycle 0 → `row_rd_en`/`row_addr`=0 cycle 1 → capture cycle 2 → first `pix_valid` with `pix_sof`=1 cycle 3.
- Handshake: while `pix_valid && !pix_ready`, `pix_data`, `pix_sof`, `pix_eol` held stable; `pix_valid` never drops without acceptance.
- With `pix_ready` held high: exactly WIDTH×HEIGHT consecutive valid beats, no bubbles.
- At most one read outstanding; `row_addr` valid only while `row_rd_en`=1 (else 0).

## Structure
- Package `gol_pkg`: default WIDTH/HEIGHT, `pixel_t` (logic [11:0]), default ALIVE/DEAD colour constants, FSM state enum.
- Sub-module `gol_row_buffer`: two WIDTH-bit registers with full flags, write-from-read-port, swap on row end, exposes front row.
- Top holds FSM, counters, prefetch control and pixel output stage.

## Test plan
- WIDTH=8, HEIGHT=4, memory row y = 8'h01<<y, `pix_ready`=1, start at cycle 0 → first beat cycle 3 with sof=1; 32 beats contiguous; beat (y,x) = FFF iff x==y; eol on every 8th beat; `frame_done` cycle 35.
- Same grid, `pix_ready` random 50% → identical 32-beat sequence; outputs stable while stalled; no `pix_valid` drop before acceptance.
- Reset asserted at beat 13 → all outputs 0 next edge; no `frame_done`; new `start` replays from (0,0) with sof.
- `start` pulsed at beats 5 and 20 → ignored, one frame only; `start` in `frame_done` cycle → second frame begins, first beat 3 cycles later.
- HEIGHT=1, WIDTH=4, row 4'b1010 → beats 000,FFF,000,FFF, sof on first, eol on last, no second read issued.
- Read-port monitor all runs → `row_addr` strictly 0..HEIGHT-1 once each, never two reads outstanding.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and defaults for the Game of Life grid reader: pixel type,
// default geometry and colours, reader FSM states and an address-width helper.
package gol_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  typedef logic [11:0] pixel_t;

  localparam pixel_t DEF_ALIVE_COLOR = 12'hFFF;
  localparam pixel_t DEF_DEAD_COLOR  = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM
  } state_t;

  // A single-row grid still needs a one-bit row address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gol_grid_reader_if.sv
// Valid/ready pixel stream carrying one cell colour per beat with
// start-of-frame and end-of-line markers.
interface gol_grid_reader_if;
  import gol_pkg::*;

  logic   pix_valid;
  logic   pix_ready;
  pixel_t pix_data;
  logic   pix_sof;
  logic   pix_eol;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_sof,
    output pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_sof,
    input  pix_eol,
    output pix_ready
  );

endinterface

// File: rtl/gol_row_buffer.sv
// Two-entry row buffer: the front row feeds the pixel stage while the back
// row is filled from the read port; a swap promotes back to front.
module gol_row_buffer
  import gol_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             swap,
  output logic [WIDTH-1:0] front,
  output logic             front_full,
  output logic             back_full
);

  logic [WIDTH-1:0] back;
  logic             front_full_sw;
  logic             back_full_sw;
  logic             wr_front;
  logic             wr_back;

  // The swap is applied first, then the incoming row lands in whichever
  // slot is empty afterwards, so a late read still fills the front row.
  always_comb begin
    front_full_sw = swap ? back_full : front_full;
    back_full_sw  = swap ? 1'b0      : back_full;
    wr_front      = wr_en && !front_full_sw;
    wr_back       = wr_en &&  front_full_sw;
  end

  // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_full <= 1'b0;
      back_full  <= 1'b0;
    end else if (clear) begin
      front_full <= 1'b0;
      back_full  <= 1'b0;
    end else begin
      front_full <= front_full_sw || wr_front;
      back_full  <= back_full_sw  || wr_back;
    end
  end

  // NOTE: row contents are not reset; the full flags alone decide whether they are meaningful.
  always_ff @(posedge clk) begin
    if (swap)     front <= back;
    if (wr_front) front <= wr_data;
    if (wr_back)  back  <= wr_data;
  end

endmodule

// File: rtl/gol_grid_reader.sv
// Streams one grid generation as raster-ordered pixels: fetches rows over a
// one-cycle-latency read port, prefetches the next row, drives valid/ready.
module gol_grid_reader
  import gol_pkg::*;
#(
  parameter int     WIDTH       = DEF_WIDTH,
  parameter int     HEIGHT      = DEF_HEIGHT,
  parameter pixel_t ALIVE_COLOR = DEF_ALIVE_COLOR,
  parameter pixel_t DEAD_COLOR  = DEF_DEAD_COLOR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          row_rd_en,
  output logic [addr_width(HEIGHT)-1:0] row_addr,
  input  logic [WIDTH-1:0]              row_data,
  gol_grid_reader_if.master             pix,
  output logic                          frame_done
);

  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = addr_width(HEIGHT);

  state_t           state;
  state_t           state_nxt;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             rd_pending;
  logic             rd_en_nxt;
  logic [Y_W-1:0]   rd_addr_nxt;

  logic [WIDTH-1:0] front_row;
  logic             front_full;
  logic             back_full;
  logic             buf_clear;
  logic             buf_swap;

  logic             valid;
  logic             accept;
  logic             end_of_row;
  logic             last_row;
  logic             last_beat;

  assign valid      = (state == ST_STREAM) && front_full;
  assign accept     = valid && pix.pix_ready;
  assign end_of_row = (x == X_W'(WIDTH - 1));
  assign last_row   = (y == Y_W'(HEIGHT - 1));
  assign last_beat  = accept && end_of_row && last_row;
  assign buf_swap   = accept && end_of_row;
  assign buf_clear  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

  gol_row_buffer #(
    .WIDTH(WIDTH)
  ) u_row_buffer (
    .clk        (clk),
    .reset      (reset),
    .clear      (buf_clear),
    .wr_en      (rd_pending),
    .wr_data    (row_data),
    .swap       (buf_swap),
    .front      (front_row),
    .front_full (front_full),
    .back_full  (back_full)
  );

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt   = state;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          rd_en_nxt = 1'b1;
        end
      end
      ST_FETCH: begin
        if (rd_pending) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_beat) begin
          state_nxt = ST_IDLE;
        end else if (!back_full && !last_row && !row_rd_en && !rd_pending) begin
          // Only one read in flight; the next row goes wherever the buffer has room.
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = y + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      row_rd_en  <= 1'b0;
      row_addr   <= '0;
      rd_pending <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      row_rd_en  <= rd_en_nxt;
      row_addr   <= rd_addr_nxt;
      rd_pending <= row_rd_en;
      frame_done <= last_beat;
      if (state == ST_IDLE && start) begin
        x <= '0;
        y <= '0;
      end else if (accept) begin
        if (end_of_row) begin
          x <= '0;
          y <= last_row ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // Pixel stage: outputs derive only from registered state, so they hold while stalled.
  assign pix.pix_valid = valid;
  assign pix.pix_data  = valid ? (front_row[x] ? ALIVE_COLOR : DEAD_COLOR) : '0;
  assign pix.pix_sof   = valid && (x == '0) && (y == '0);
  assign pix.pix_eol   = valid && end_of_row;

endmodule

// File: tb/tb_gol_grid_reader.sv
// Self-checking bench for gol_grid_reader: an 8x4 diagonal grid and a 4x1 grid,
// table-driven beat checks plus stall, restart and mid-frame reset sequences.
module tb_gol_grid_reader;
  import gol_pkg::*;

  typedef struct {
    pixel_t data;
    logic   sof;
    logic   eol;
  } vec_t;

  typedef struct {
    pixel_t data;
    logic   sof;
    logic   eol;
    int     cyc;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic rand_mode = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 8x4 grid, row y = 1 << y
  logic       a_start, a_busy, a_rd_en, a_fd;
  logic [1:0] a_addr;
  logic [7:0] a_data;
  gol_grid_reader_if pa ();
  assign a_start = start && !sel;
  assign pa.pix_ready = ready;

  gol_grid_reader #(.WIDTH(8), .HEIGHT(4), .ALIVE_COLOR(12'hFFF), .DEAD_COLOR(12'h000)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy),
    .row_rd_en(a_rd_en), .row_addr(a_addr), .row_data(a_data),
    .pix(pa), .frame_done(a_fd)
  );

  always @(posedge clk) if (a_rd_en) a_data <= 8'h01 << a_addr;

  // DUT B: 4x1 grid, single row 4'b1010
  logic       b_start, b_busy, b_rd_en, b_fd;
  logic [0:0] b_addr;
  logic [3:0] b_data;
  gol_grid_reader_if pb ();
  assign b_start = start && sel;
  assign pb.pix_ready = ready;

  gol_grid_reader #(.WIDTH(4), .HEIGHT(1), .ALIVE_COLOR(12'hFFF), .DEAD_COLOR(12'h000)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy),
    .row_rd_en(b_rd_en), .row_addr(b_addr), .row_data(b_data),
    .pix(pb), .frame_done(b_fd)
  );

  always @(posedge clk) if (b_rd_en) b_data <= 4'b1010;

  // Observation mux: only the selected DUT is exercised at any time
  logic   m_valid, m_ready, m_sof, m_eol, m_rd_en, m_fd, m_busy;
  pixel_t m_data;
  int     m_addr;
  assign m_valid = sel ? pb.pix_valid : pa.pix_valid;
  assign m_ready = ready;
  assign m_data  = sel ? pb.pix_data  : pa.pix_data;
  assign m_sof   = sel ? pb.pix_sof   : pa.pix_sof;
  assign m_eol   = sel ? pb.pix_eol   : pa.pix_eol;
  assign m_rd_en = sel ? b_rd_en      : a_rd_en;
  assign m_fd    = sel ? b_fd         : a_fd;
  assign m_busy  = sel ? b_busy       : a_busy;
  assign m_addr  = sel ? int'(b_addr) : int'(a_addr);

  always @(posedge clk) begin
    #1;
    if (rand_mode) ready = 1'($urandom_range(0, 1));
    else           ready = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  vec_t  vec_a[32];
  vec_t  vec_b[4];
  beat_t beats[$];
  int    fd_q[$];

  // Monitors: read port ordering, stall stability, beat and frame_done capture
  int     reads = 0;
  logic   prev_rd = 1'b0;
  logic   held = 1'b0;
  pixel_t h_data;
  logic   h_sof, h_eol;

  always @(negedge clk) begin
    if (reset) begin
      reads   = 0;
      prev_rd = 1'b0;
      held    = 1'b0;
    end else begin
      if (m_rd_en) begin
        check("rd_addr", m_addr, reads);
        check("rd_one_outstanding", int'(prev_rd), 0);
        reads++;
      end else begin
        check("rd_addr_idle", m_addr, 0);
      end
      prev_rd = m_rd_en;
      if (held) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_data", int'(m_data), int'(h_data));
        check("stall_sof", int'(m_sof), int'(h_sof));
        check("stall_eol", int'(m_eol), int'(h_eol));
      end
      held  = m_valid && !m_ready;
      h_data = m_data;
      h_sof  = m_sof;
      h_eol  = m_eol;
      if (m_valid && m_ready) beats.push_back('{m_data, m_sof, m_eol, cyc});
      if (m_fd) begin
        fd_q.push_back(cyc);
        check("reads_per_frame", reads, sel ? 1 : 4);
        check("busy_at_done", int'(m_busy), 0);
        reads = 0;
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, int'(m_valid), 0);
    check({tag, "_data"},  int'(m_data),  0);
    check({tag, "_sof"},   int'(m_sof),   0);
    check({tag, "_eol"},   int'(m_eol),   0);
    check({tag, "_busy"},  int'(m_busy),  0);
    check({tag, "_rd_en"}, int'(m_rd_en), 0);
    check({tag, "_addr"},  m_addr,        0);
    check({tag, "_done"},  int'(m_fd),    0);
  endtask

  task automatic do_start(output int t0);
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", int'(m_busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (fd_q.size() == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("frame_done_seen", fd_q.size(), 1);
  endtask

  task automatic wait_beats(input int k);
    int n;
    n = 0;
    while (beats.size() < k && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("beat_reached", int'(beats.size() >= k), 1);
  endtask

  task automatic check_frame(input string tag, input int t0, input bit contig);
    int   n;
    vec_t v;
    n = sel ? 4 : 32;
    check({tag, "_beats"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      v = sel ? vec_b[i] : vec_a[i];
      check($sformatf("%s_data[%0d]", tag, i), int'(beats[i].data), int'(v.data));
      check($sformatf("%s_sof[%0d]", tag, i),  int'(beats[i].sof),  int'(v.sof));
      check($sformatf("%s_eol[%0d]", tag, i),  int'(beats[i].eol),  int'(v.eol));
      if (contig) check($sformatf("%s_cycle[%0d]", tag, i), beats[i].cyc, t0 + 3 + i);
    end
    if (contig && fd_q.size() > 0) check({tag, "_done_cycle"}, fd_q[0], t0 + 3 + n);
  endtask

  initial begin
    int t0, t1, n;

    // Expected beats: diagonal grid is alive only where x == y
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++)
        vec_a[yy * 8 + xx] = '{(xx == yy) ? 12'hFFF : 12'h000, (xx == 0 && yy == 0), (xx == 7)};
    vec_b[0] = '{12'h000, 1'b1, 1'b0};
    vec_b[1] = '{12'hFFF, 1'b0, 1'b0};
    vec_b[2] = '{12'h000, 1'b0, 1'b0};
    vec_b[3] = '{12'hFFF, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // Full frame with sink always ready: contiguous beats, frame_done at +35
    beats.delete(); fd_q.delete();
    do_start(t0);
    wait_done(100);
    check_frame("ready", t0, 1'b1);
    repeat (3) @(posedge clk);

    // Random back-pressure: same beat sequence
    rand_mode = 1'b1;
    beats.delete(); fd_q.delete();
    do_start(t0);
    wait_done(600);
    check_frame("random", t0, 1'b0);
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);

    // start during a frame is ignored
    beats.delete(); fd_q.delete();
    do_start(t0);
    wait_beats(5);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_beats(20);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(100);
    check_frame("ignore", t0, 1'b1);
    repeat (40) @(posedge clk);
    check("ignore_one_frame", fd_q.size(), 1);
    check("ignore_no_extra_beats", beats.size(), 32);

    // start in the frame_done cycle begins the next frame
    beats.delete(); fd_q.delete();
    do_start(t0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_fd && n < 100);
    check("restart_done_seen", int'(m_fd), 1);
    start = 1'b1;
    t1 = cyc;
    check("restart_cycle", t1, t0 + 35);
    @(posedge clk);
    #1 start = 1'b0;
    check("restart_busy", int'(m_busy), 1);
    check_frame("first", t0, 1'b1);
    beats.delete(); fd_q.delete();
    wait_done(100);
    check_frame("second", t1, 1'b1);
    repeat (3) @(posedge clk);

    // Reset mid-frame abandons it; a new start replays from (0,0)
    beats.delete(); fd_q.delete();
    do_start(t0);
    wait_beats(13);
    #2 reset = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    repeat (10) @(posedge clk);
    check("midrst_no_done", fd_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    beats.delete();
    do_start(t0);
    wait_done(100);
    check_frame("replay", t0, 1'b1);
    repeat (3) @(posedge clk);

    // Single-row 4-wide grid
    sel = 1'b1;
    @(negedge clk);
    check_idle("b_idle");
    beats.delete(); fd_q.delete();
    do_start(t0);
    wait_done(50);
    check_frame("one_row", t0, 1'b1);
    repeat (5) @(posedge clk);
    check("one_row_single_done", fd_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
